bp_io_req_arbiter: RTL and testbench
====================================

# bp_io_req_arbiter

Round-robin arbiter and per-LCE credit manager in front of the I/O CCE. It merges `num_req_p` uncached LCE request streams onto the single request port of the I/O CCE. It counts each requester's in-flight uncached operations and frees a credit when the matching LCE command (`uc_data` or `uc_st_done`) leaves the I/O CCE. It bounds outstanding I/O traffic per core and keeps the I/O CCE's valid/ready contract stable.

## Interface
- `num_req_p`, 2: number of requesting LCEs (≥2).
- `req_width_p`, `lce_cce_req_width_lp`: request message width; messages pass through opaquely.
- `lce_id_width_p`, from proc params: LCE id width.
- `max_credits_p`, 4: max outstanding requests per requester (1..15).

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `reset_i`  in  1  synchronous, active-high reset.
- `lce_ids_i`  in  `num_req_p*lce_id_width_p`  LCE id of each requester slot; quasi-static.
- `req_i`  in  `num_req_p*req_width_p`  request messages.
- `req_v_i`  in  `num_req_p`  per-slot valid.
- `req_yumi_o`  out  `num_req_p`  per-slot consume; at most one bit set.
- `req_o`  out  `req_width_p`  granted message, to the I/O CCE `lce_req_i`.
- `req_v_o`  out  1  granted valid.
- `req_yumi_i`  in  1  consume from the I/O CCE.
- `cmd_done_v_i`  in  1  an LCE command left the I/O CCE this cycle (`lce_cmd_v_o & lce_cmd_ready_i`).
- `cmd_done_lce_id_i`  in  `lce_id_width_p`  `dst_id` of that command.
- `credit_err_o`  out  1  sticky; a return arrived with no matching outstanding credit.

## Operation
- State:
  - `credits_r[k]`: count 0..`max_credits_p`.
  - `rr_ptr_r`: priority start slot.
  - `locked_r` and `grant_r`: held grant.
- Eligibility: slot k is eligible when `req_v_i[k]` is high and `credits_r[k] < max_credits_p`.
- State machine:
  - IDLE (`locked_r=0`): choose the first eligible slot, searching from `rr_ptr_r` upward and wrapping modulo `num_req_p`. Drive `req_o`/`req_v_o` from that slot in the same cycle.
    - If `req_yumi_i` is high, the grant completes and the state stays IDLE.
    - If `req_yumi_i` is low, go to LOCKED with `grant_r` set to that slot.
  - LOCKED: `req_o`/`req_v_o` follow slot `grant_r` only; eligibility is not re-evaluated.
    - On `req_yumi_i`, go to IDLE.
    - If `req_v_i[grant_r]` drops (protocol violation), go to IDLE without consuming.
- Grant completion (`req_yumi_i & req_v_o`):
  - `req_yumi_o[g]=1`.
  - `credits_r[g]++`.
  - `rr_ptr_r = (g+1) mod num_req_p`.
- Credit return (`cmd_done_v_i`):
  - Decrement the credit of the lowest slot k with `lce_ids_i[k]==cmd_done_lce_id_i` and `credits_r[k]>0`.
  - If no slot matches, leave credits unchanged and set `credit_err_o`.
- Same-slot increment and decrement in one cycle: the credit count is unchanged.
- Credits never wrap: increment at max is impossible (slot not eligible); decrement at 0 takes the error path.

## Timing
- Zero-cycle pass-through: `req_v_o` and `req_yumi_o` are combinational from `req_v_i`, the credits and `req_yumi_i`. There is no path from `req_yumi_i` to `req_v_o`.
- Valid/ready stability: once `req_v_o` is high, `req_o` and the grant stay fixed until `req_yumi_i` arrives.
- A credit returned in cycle t makes the slot eligible in cycle t+1.
- Reset values:
  - `req_v_o=0`, `req_yumi_o=0`, `credit_err_o=0`.
  - All credits 0, `rr_ptr_r=0`, `locked_r=0`.
- Reset mid-operation: all state clears. Responses to requests issued before reset take the error path, so `credit_err_o` may set; the bench tolerates this after reset.

## Configuration
- `BP_IO_ARB_SERIALIZE_EN`:
  - Defined: adds a global outstanding counter. A slot is eligible only when the sum of all credits is 0, so at most one I/O operation is in flight system-wide (strict ordering for side-effecting devices).
  - Undefined: only the per-slot `max_credits_p` limit applies.

## Test plan
- Single requester: slot 0 issues 4 requests with `req_yumi_i` always high → 4 grants in 4 cycles; the 5th request is blocked (`req_v_o=0`) until one `cmd_done` with slot 0's id, then granted the next cycle.
- Fairness: both slots continuously valid, credits returned every cycle → grants alternate 0,1,0,1.
- Backpressure: `req_yumi_i` low for 3 cycles while slot 1 is granted and slot 0 also valid → `req_o` stays slot 1's payload for all 3 cycles; slot 1 is consumed on the 4th cycle, then slot 0.
- Simultaneous grant and return on slot 0 with credits=2 → credits stay 2.
- Spurious return with an unknown id → `credit_err_o` rises next cycle and stays high until reset; credits unchanged.
- With `BP_IO_ARB_SERIALIZE_EN` defined: slots 0 and 1 both valid → slot 0 granted; slot 1 is held off until slot 0's `cmd_done`, then granted the following cycle.

Source files
------------

// File: rtl/bp_io_req_arbiter.sv
// Round-robin arbiter + per-LCE credit manager in front of the I/O CCE request port.
// Latency: zero-cycle pass-through; the grant is combinational from valids and credits.
// Backpressure: a grant that is not consumed is held (locked) until req_yumi_i arrives.
//
// Ports:
//   clk_i, reset_i         clock; synchronous active-high reset
//   lce_ids_i              LCE id of each requester slot (quasi-static)
//   req_i / req_v_i        per-slot request messages and valids
//   req_yumi_o             per-slot consume (one-hot or zero)
//   req_o / req_v_o        granted message towards the I/O CCE
//   req_yumi_i             consume from the I/O CCE
//   cmd_done_v_i / _lce_id_i  an LCE command left the I/O CCE; frees one credit
//   credit_err_o           sticky: a return found no matching outstanding credit
//
// Optional feature macro: BP_IO_ARB_SERIALIZE_EN
//   When defined, a global outstanding counter allows at most one I/O
//   operation in flight across all requesters.
module bp_io_req_arbiter #(
  parameter int num_req_p            = 2,
  parameter int lce_id_width_p       = 4,
  parameter int lce_cce_req_width_lp = 32,
  parameter int req_width_p          = lce_cce_req_width_lp,
  parameter int max_credits_p        = 4
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic [num_req_p*lce_id_width_p-1:0] lce_ids_i,
  input  logic [num_req_p*req_width_p-1:0]    req_i,
  input  logic [num_req_p-1:0]                req_v_i,
  output logic [num_req_p-1:0]                req_yumi_o,
  output logic [req_width_p-1:0]              req_o,
  output logic                                req_v_o,
  input  logic                                req_yumi_i,
  input  logic                                cmd_done_v_i,
  input  logic [lce_id_width_p-1:0]           cmd_done_lce_id_i,
  output logic                                credit_err_o
);

  localparam int idx_w_lp  = $clog2(num_req_p);
  // Four bits covers the full 1..15 credit range.
  localparam int cred_w_lp = 4;
  localparam logic [cred_w_lp-1:0] max_cred_lp  = cred_w_lp'(max_credits_p);
  localparam logic [idx_w_lp-1:0]  last_idx_lp  = idx_w_lp'(num_req_p - 1);

  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_LOCKED = 1'b1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [cred_w_lp-1:0] credits_q [num_req_p];
  logic [cred_w_lp-1:0] credits_d [num_req_p];
  logic [idx_w_lp-1:0]  rr_ptr_q, rr_ptr_d;
  logic                 locked_q, locked_d;
  logic [idx_w_lp-1:0]  grant_q, grant_d;
  logic                 err_q, err_d;

`ifdef BP_IO_ARB_SERIALIZE_EN
  localparam int tot_w_lp = $clog2(num_req_p * max_credits_p + 1);
  logic [tot_w_lp-1:0]  total_q, total_d;
`endif

  // ---------------------------------------------------------------------------
  // Eligibility and round-robin pick
  // ---------------------------------------------------------------------------
  logic [num_req_p-1:0] eligible;
  logic                 pick_found;
  logic [idx_w_lp-1:0]  pick_idx;

  always_comb begin
    eligible = '0;
    for (int k = 0; k < num_req_p; k++) begin
      eligible[k] = req_v_i[k] && (credits_q[k] < max_cred_lp);
    end
`ifdef BP_IO_ARB_SERIALIZE_EN
    // Anything in flight anywhere blocks every requester.
    if (total_q != '0) begin
      eligible = '0;
    end
`endif
  end

  // First eligible slot at or after rr_ptr_q, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = rr_ptr_q;
    for (int i = 0; i < num_req_p; i++) begin
      if (!pick_found && eligible[(int'(rr_ptr_q) + i) % num_req_p]) begin
        pick_found = 1'b1;
        pick_idx   = idx_w_lp'((int'(rr_ptr_q) + i) % num_req_p);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output selection. While locked, only the held slot drives the output and
  // eligibility is ignored, so req_o cannot change under a pending valid.
  // req_yumi_i never feeds req_v_o.
  // ---------------------------------------------------------------------------
  logic                sel_v;
  logic [idx_w_lp-1:0] sel_idx;
  logic                grant_fire;

  always_comb begin
    if (locked_q == ST_LOCKED) begin
      sel_idx = grant_q;
      sel_v   = req_v_i[grant_q];
    end else begin
      sel_idx = pick_idx;
      sel_v   = pick_found;
    end
  end

  assign req_v_o    = sel_v;
  assign grant_fire = sel_v & req_yumi_i;

  always_comb begin
    req_o      = '0;
    req_yumi_o = '0;
    for (int k = 0; k < num_req_p; k++) begin
      if (sel_idx == idx_w_lp'(k)) begin
        req_o = req_i[k*req_width_p +: req_width_p];
      end
      req_yumi_o[k] = grant_fire && (sel_idx == idx_w_lp'(k));
    end
  end

  // ---------------------------------------------------------------------------
  // Credit return: lowest slot with a matching id that still holds a credit.
  // ---------------------------------------------------------------------------
  logic                ret_found;
  logic [idx_w_lp-1:0] ret_idx;
  logic                ret_fire;

  always_comb begin
    ret_found = 1'b0;
    ret_idx   = '0;
    for (int k = 0; k < num_req_p; k++) begin
      if (!ret_found
          && (lce_ids_i[k*lce_id_width_p +: lce_id_width_p] == cmd_done_lce_id_i)
          && (credits_q[k] != '0)) begin
        ret_found = 1'b1;
        ret_idx   = idx_w_lp'(k);
      end
    end
  end

  assign ret_fire = cmd_done_v_i & ret_found;

  // ---------------------------------------------------------------------------
  // Next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int k = 0; k < num_req_p; k++) begin
      logic inc;
      logic dec;
      inc = grant_fire && (sel_idx == idx_w_lp'(k));
      dec = ret_fire   && (ret_idx == idx_w_lp'(k));
      credits_d[k] = credits_q[k];
      // Increment and decrement on the same slot cancel out.
      if (inc && !dec) begin
        credits_d[k] = credits_q[k] + 1'b1;
      end else if (dec && !inc) begin
        credits_d[k] = credits_q[k] - 1'b1;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_fire) begin
      rr_ptr_d = (sel_idx == last_idx_lp) ? '0 : sel_idx + 1'b1;
    end
  end

  always_comb begin
    locked_d = locked_q;
    grant_d  = grant_q;
    if (locked_q == ST_IDLE) begin
      if (pick_found && !req_yumi_i) begin
        locked_d = ST_LOCKED;
        grant_d  = pick_idx;
      end
    end else begin
      // A dropped valid is a requester protocol violation; release without
      // consuming so the arbiter cannot wedge on a vanished request.
      if (req_yumi_i || !req_v_i[grant_q]) begin
        locked_d = ST_IDLE;
      end
    end
  end

  assign err_d        = err_q | (cmd_done_v_i & ~ret_found);
  assign credit_err_o = err_q;

`ifdef BP_IO_ARB_SERIALIZE_EN
  always_comb begin
    total_d = total_q;
    if (grant_fire && !ret_fire) begin
      total_d = total_q + 1'b1;
    end else if (ret_fire && !grant_fire) begin
      total_d = total_q - 1'b1;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int k = 0; k < num_req_p; k++) begin
        credits_q[k] <= '0;
      end
      rr_ptr_q <= '0;
      locked_q <= ST_IDLE;
      grant_q  <= '0;
      err_q    <= 1'b0;
`ifdef BP_IO_ARB_SERIALIZE_EN
      total_q  <= '0;
`endif
    end else begin
      for (int k = 0; k < num_req_p; k++) begin
        credits_q[k] <= credits_d[k];
      end
      rr_ptr_q <= rr_ptr_d;
      locked_q <= locked_d;
      grant_q  <= grant_d;
      err_q    <= err_d;
`ifdef BP_IO_ARB_SERIALIZE_EN
      total_q  <= total_d;
`endif
    end
  end

endmodule

// File: tb/tb_bp_io_req_arbiter.sv
// Self-checking bench for bp_io_req_arbiter.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Expected grants are queued when stimulus is planned and popped when the DUT consumes.
module tb_bp_io_req_arbiter;

  localparam int N   = 2;
  localparam int W   = 16;
  localparam int IDW = 4;
  localparam int MC  = 4;

  localparam logic [IDW-1:0] ID0 = 4'd3;
  localparam logic [IDW-1:0] ID1 = 4'd5;

  logic           clk = 1'b0;
  logic           reset;
  logic [N*IDW-1:0] lce_ids;
  logic [N*W-1:0] req_i;
  logic [N-1:0]   req_v_i;
  logic [N-1:0]   yumi_o;
  logic [W-1:0]   req_o;
  logic           req_v_o;
  logic           yumi_i;
  logic           done_v;
  logic [IDW-1:0] done_id;
  logic           err;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [N-1:0] sel;
    logic [W-1:0] dat;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  bp_io_req_arbiter #(
    .num_req_p      (N),
    .lce_id_width_p (IDW),
    .req_width_p    (W),
    .max_credits_p  (MC)
  ) dut (
    .clk_i             (clk),
    .reset_i           (reset),
    .lce_ids_i         (lce_ids),
    .req_i             (req_i),
    .req_v_i           (req_v_i),
    .req_yumi_o        (yumi_o),
    .req_o             (req_o),
    .req_v_o           (req_v_o),
    .req_yumi_i        (yumi_i),
    .cmd_done_v_i      (done_v),
    .cmd_done_lce_id_i (done_id),
    .credit_err_o      (err)
  );

  // Scoreboard: every consumed grant must match the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && req_v_o && yumi_i) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_grant: got sel=%b dat=%h, required no grant", yumi_o, req_o);
      end else begin
        e = exp_q.pop_front();
        if (yumi_o !== e.sel || req_o !== e.dat) begin
          n_fail++;
          $display("FAIL sb_grant: got sel=%b dat=%h, required sel=%b dat=%h",
                   yumi_o, req_o, e.sel, e.dat);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset   = 1'b1;
    req_v_i = '0;
    req_i   = '0;
    yumi_i  = 1'b0;
    done_v  = 1'b0;
    done_id = '0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    lce_ids = {ID1, ID0};
    req_v_i = '0;
    req_i   = '0;
    yumi_i  = 1'b0;
    done_v  = 1'b0;
    done_id = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    n_checks++;
    if (req_v_o !== 1'b0) begin n_fail++; $display("FAIL rst_req_v: got %b, required 0", req_v_o); end
    n_checks++;
    if (yumi_o !== 2'b00) begin n_fail++; $display("FAIL rst_yumi: got %b, required 00", yumi_o); end
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b, required 0", err); end
    next_cycle();
    reset   = 1'b0;
    // Round-robin pointer starts at slot 0.
    req_v_i = 2'b11;
    req_i   = {16'h5111, 16'h5000};
    @(negedge clk);
    n_checks++;
    if (req_v_o !== 1'b1 || req_o !== 16'h5000 || yumi_o !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_first_pick: got v=%b dat=%h yumi=%b, required v=1 dat=5000 yumi=00",
               req_v_o, req_o, yumi_o);
    end
    req_v_i = '0;
    next_cycle();
  endtask

  task automatic test_single();
    apply_reset();
    for (int c = 0; c <= MC; c++) exp_q.push_back({2'b01, W'(16'hA000 + c)});
    yumi_i  = 1'b1;
    req_v_i = 2'b01;
    for (int c = 0; c < MC; c++) begin
      req_i[W-1:0] = W'(16'hA000 + c);
      @(negedge clk);
      n_checks++;
      if (req_v_o !== 1'b1) begin n_fail++; $display("FAIL single_grant%0d: got v=%b, required 1", c, req_v_o); end
      next_cycle();
    end
    req_i[W-1:0] = 16'hA004;
    @(negedge clk);
    n_checks++;
    if (req_v_o !== 1'b0) begin n_fail++; $display("FAIL single_blocked: got v=%b, required 0", req_v_o); end
    next_cycle();
    done_v  = 1'b1;
    done_id = ID0;
    @(negedge clk);
    n_checks++;
    if (req_v_o !== 1'b0) begin n_fail++; $display("FAIL single_return_cycle: got v=%b, required 0", req_v_o); end
    next_cycle();
    done_v = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req_v_o !== 1'b1) begin n_fail++; $display("FAIL single_after_return: got v=%b, required 1", req_v_o); end
    next_cycle();
    req_v_i = '0;
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL single_drain: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_fairness();
    apply_reset();
    yumi_i  = 1'b1;
    req_v_i = 2'b11;
    for (int c = 0; c < 6; c++) begin
      req_i = {W'(16'hB100 + c), W'(16'hB000 + c)};
      exp_q.push_back((c % 2 == 0) ? {2'b01, W'(16'hB000 + c)} : {2'b10, W'(16'hB100 + c)});
      // Return the credit of the previous cycle's grant.
      done_v  = (c > 0);
      done_id = (c % 2 == 1) ? ID0 : ID1;
      @(negedge clk);
      next_cycle();
    end
    done_v  = 1'b0;
    req_v_i = '0;
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL fair_drain: got %0d pending, required 0", exp_q.size()); end
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL fair_err: got %b, required 0", err); end
  endtask

  task automatic test_backpressure();
    apply_reset();
    // Advance the pointer to slot 1.
    yumi_i       = 1'b1;
    req_v_i      = 2'b01;
    req_i[W-1:0] = 16'hC0FF;
    exp_q.push_back({2'b01, 16'hC0FF});
    @(negedge clk);
    next_cycle();
    req_v_i = 2'b11;
    req_i   = {16'hC100, 16'hC000};
    yumi_i  = 1'b0;
    exp_q.push_back({2'b10, 16'hC100});
    exp_q.push_back({2'b01, 16'hC000});
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (req_v_o !== 1'b1 || req_o !== 16'hC100 || yumi_o !== 2'b00) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got v=%b dat=%h yumi=%b, required v=1 dat=c100 yumi=00",
                 c, req_v_o, req_o, yumi_o);
      end
      next_cycle();
    end
    yumi_i = 1'b1;
    @(negedge clk);
    next_cycle();
    req_v_i = 2'b01;
    @(negedge clk);
    next_cycle();
    req_v_i = '0;
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL bp_drain: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_lock_drop();
    apply_reset();
    req_v_i = 2'b11;
    req_i   = {16'h7100, 16'h7000};
    yumi_i  = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req_v_o !== 1'b1 || req_o !== 16'h7000) begin
      n_fail++;
      $display("FAIL lock_first: got v=%b dat=%h, required v=1 dat=7000", req_v_o, req_o);
    end
    next_cycle();
    // Locked on slot 0; slot 0 drops, slot 1 must not leak through this cycle.
    req_v_i = 2'b10;
    @(negedge clk);
    n_checks++;
    if (req_v_o !== 1'b0) begin n_fail++; $display("FAIL lock_drop: got v=%b, required 0", req_v_o); end
    next_cycle();
    yumi_i = 1'b1;
    exp_q.push_back({2'b10, 16'h7100});
    @(negedge clk);
    next_cycle();
    req_v_i = '0;
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL lock_drain: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_same_cycle();
    apply_reset();
    yumi_i  = 1'b1;
    req_v_i = 2'b01;
    for (int c = 0; c < 5; c++) exp_q.push_back({2'b01, W'(16'hD000 + c)});
    for (int c = 0; c < 5; c++) begin
      req_i[W-1:0] = W'(16'hD000 + c);
      // Third grant coincides with a return while the slot holds 2 credits.
      done_v  = (c == 2);
      done_id = ID0;
      @(negedge clk);
      n_checks++;
      if (req_v_o !== 1'b1) begin n_fail++; $display("FAIL same_grant%0d: got v=%b, required 1", c, req_v_o); end
      next_cycle();
    end
    done_v       = 1'b0;
    req_i[W-1:0] = 16'hD0FF;
    @(negedge clk);
    n_checks++;
    if (req_v_o !== 1'b0) begin n_fail++; $display("FAIL same_limit: got v=%b, required 0", req_v_o); end
    next_cycle();
    req_v_i = '0;
    n_checks++;
    if (exp_q.size() != 0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL same_drain: got pending=%0d err=%b, required 0 and 0", exp_q.size(), err);
    end
  endtask

  task automatic test_spurious();
    apply_reset();
    yumi_i       = 1'b1;
    req_v_i      = 2'b01;
    req_i[W-1:0] = 16'hE000;
    exp_q.push_back({2'b01, 16'hE000});
    @(negedge clk);
    next_cycle();
    req_v_i = '0;
    done_v  = 1'b1;
    done_id = 4'd9;
    @(negedge clk);
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL spur_same_cycle: got err=%b, required 0", err); end
    next_cycle();
    done_v = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (err !== 1'b1) begin n_fail++; $display("FAIL spur_sticky%0d: got err=%b, required 1", c, err); end
      next_cycle();
    end
    // Slot 0 still holds exactly one credit: three more grants, then blocked.
    req_v_i = 2'b01;
    for (int c = 1; c < MC; c++) begin
      req_i[W-1:0] = W'(16'hE000 + c);
      exp_q.push_back({2'b01, W'(16'hE000 + c)});
      @(negedge clk);
      next_cycle();
    end
    @(negedge clk);
    n_checks++;
    if (req_v_o !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL spur_credits: got v=%b pending=%0d, required v=0 pending=0", req_v_o, exp_q.size());
    end
    next_cycle();
    req_v_i = '0;
    reset   = 1'b1;
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL spur_reset_clear: got err=%b, required 0", err); end
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_serialize();
    apply_reset();
    yumi_i  = 1'b1;
    req_v_i = 2'b11;
    req_i   = {16'hF100, 16'hF000};
    exp_q.push_back({2'b01, 16'hF000});
    @(negedge clk);
    next_cycle();
    req_v_i = 2'b10;
    @(negedge clk);
    n_checks++;
    if (req_v_o !== 1'b0) begin n_fail++; $display("FAIL ser_hold: got v=%b, required 0", req_v_o); end
    next_cycle();
    done_v  = 1'b1;
    done_id = ID0;
    @(negedge clk);
    n_checks++;
    if (req_v_o !== 1'b0) begin n_fail++; $display("FAIL ser_return_cycle: got v=%b, required 0", req_v_o); end
    next_cycle();
    done_v = 1'b0;
    exp_q.push_back({2'b10, 16'hF100});
    @(negedge clk);
    n_checks++;
    if (req_v_o !== 1'b1) begin n_fail++; $display("FAIL ser_release: got v=%b, required 1", req_v_o); end
    next_cycle();
    req_v_i = '0;
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL ser_drain: got %0d pending, required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
`ifdef BP_IO_ARB_SERIALIZE_EN
    test_serialize();
`else
    test_single();
    test_fairness();
    test_backpressure();
    test_lock_drop();
    test_same_cycle();
    test_spurious();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "timeout");
  end

endmodule
